// File: rtl/mc145k_pkg.sv
// Shared definitions for the MC145k program/IO sequencer: ICU opcodes and
// program-word field helpers.
package mc145k_pkg;

  localparam int INST_W = 4;

  localparam logic [INST_W-1:0] NOPO = 4'h0;
  localparam logic [INST_W-1:0] LD   = 4'h1;
  localparam logic [INST_W-1:0] LDC  = 4'h2;
  localparam logic [INST_W-1:0] AND  = 4'h3;
  localparam logic [INST_W-1:0] ANDC = 4'h4;
  localparam logic [INST_W-1:0] OR   = 4'h5;
  localparam logic [INST_W-1:0] ORC  = 4'h6;
  localparam logic [INST_W-1:0] XNOR = 4'h7;
  localparam logic [INST_W-1:0] STO  = 4'h8;
  localparam logic [INST_W-1:0] STOC = 4'h9;
  localparam logic [INST_W-1:0] IEN  = 4'hA;
  localparam logic [INST_W-1:0] OEN  = 4'hB;
  localparam logic [INST_W-1:0] JMP  = 4'hC;
  localparam logic [INST_W-1:0] RTN  = 4'hD;
  localparam logic [INST_W-1:0] SKZ  = 4'hE;
  localparam logic [INST_W-1:0] NOPF = 4'hF;

  // Program words are {inst, operand}; word is zero-extended to 32 bits.
  function automatic logic [INST_W-1:0] inst_of(input logic [31:0] word, input int pc_w);
    return INST_W'(word >> pc_w);
  endfunction

endpackage

// File: rtl/mc145k_ret_stack.sv
// Return-address LIFO for the sequencer: count-pointer based, push and pop
// never arrive together; overflow/underflow are reported via full/empty.
module mc145k_ret_stack
  import mc145k_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_idx = IDX_W'(count_reg);
  assign top_idx  = IDX_W'(count_reg - CNT_W'(1));
  assign top_data = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (push && !full) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage carries no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (rst_n && push && !full) begin
      mem[push_idx] <= push_data;
    end
  end

endmodule

// File: rtl/mc145k_sequencer.sv
// Program counter, ROM fetch and board IO for the 1-bit ICU; reacts to the
// ICU strobes one cycle after the instruction that raised them.
module mc145k_sequencer
  import mc145k_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int IO_AW        = 3,
  parameter int STACK_DEPTH  = 4,
  parameter int LOOP_ON_NOPO = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PC_W-1:0]      prog_addr,
  input  logic [INST_W+PC_W-1:0] prog_data,
  output logic [INST_W-1:0]    i_inst,
  output logic                 i_data,
  input  logic                 write,
  input  logic                 o_data,
  input  logic                 jmp,
  input  logic                 rtn,
  input  logic                 flag0,
  input  logic                 flagf,
  input  logic [2**IO_AW-1:0]  in_port,
  output logic [2**IO_AW-1:0]  out_port,
  output logic                 stk_err
);

  localparam int IO_N = 2**IO_AW;

  logic [PC_W-1:0] pc_reg, pc_next, pc_inc;
  logic [PC_W-1:0] prev_opnd_reg, operand, stk_top;
  logic            squash_reg, call_arm_reg, stk_err_reg;
  logic [IO_N-1:0] out_reg, wr_sel;
  logic            live, do_write, do_jmp, do_rtn, do_flag0;
  logic            push, pop, stk_full, stk_empty;

  assign operand   = prog_data[PC_W-1:0];
  assign prog_addr = pc_reg;
  assign i_inst    = rst_n ? inst_of(32'(prog_data), PC_W) : NOPO;
  assign i_data    = in_port[operand[IO_AW-1:0]];
  assign out_port  = out_reg;
  assign stk_err   = stk_err_reg;

  // Strobes belong to the previous instruction; drop them around reset.
  assign live     = rst_n && !squash_reg;
  assign do_write = live && write;
  assign do_jmp   = live && jmp;
  assign do_rtn   = live && rtn;
  assign do_flag0 = live && flag0;
  assign push     = do_jmp && call_arm_reg;
  assign pop      = do_rtn;
  assign pc_inc   = pc_reg + PC_W'(1);

  mc145k_ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    pc_next = pc_inc;
    if (do_rtn) begin
      pc_next = stk_empty ? '0 : stk_top;
    end else if (do_jmp) begin
      pc_next = prev_opnd_reg;
    end else if (do_flag0 && (LOOP_ON_NOPO != 0)) begin
      pc_next = '0;
    end
  end

  for (genvar gi = 0; gi < IO_N; gi++) begin : g_wr_sel
    assign wr_sel[gi] = do_write && (prev_opnd_reg[IO_AW-1:0] == IO_AW'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg        <= '0;
      prev_opnd_reg <= '0;
      call_arm_reg  <= 1'b0;
      squash_reg    <= 1'b1;
      stk_err_reg   <= 1'b0;
      out_reg       <= '0;
    end else begin
      pc_reg        <= pc_next;
      prev_opnd_reg <= operand;
      call_arm_reg  <= flagf && !squash_reg;
      squash_reg    <= 1'b0;
      out_reg       <= (out_reg & ~wr_sel) | (wr_sel & {IO_N{o_data}});
      if ((push && stk_full) || (pop && stk_empty)) begin
        stk_err_reg <= 1'b1;
      end
    end
  end

endmodule
